// File: rtl/decoder_onehot_ctrl_if.sv
// Code handshake between an encoder-side producer and the one-hot decoder.
interface decoder_onehot_ctrl_if #(
  parameter int IN_W = 2
) ();
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] a;

  modport master (output in_valid, output a, input in_ready);
  modport slave  (input in_valid, input a, output in_ready);
endinterface

// File: rtl/decoder_onehot_ctrl.sv
// Sequential binary-to-one-hot decoder: each accepted code drives y for HOLD cycles, then GAP idle cycles.
// Define DECODER_ONEHOT_STICKY_ERR_EN for a sticky err cleared by the extra err_clr input.
module decoder_onehot_ctrl #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4,
  parameter int HOLD  = 3,
  parameter int GAP   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_onehot_ctrl_if.slave bus,
  output logic [OUT_W-1:0]     y,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 err
`ifdef DECODER_ONEHOT_STICKY_ERR_EN
  ,
  input  logic                 err_clr
`endif
);

  localparam int MAX_HG = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W  = $clog2(MAX_HG + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  code;
  logic             accept;
  logic             code_ok;
  logic             bad_accept;

  assign code       = bus.a;
  assign accept     = bus.in_valid && bus.in_ready;
  assign code_ok    = int'(code) < OUT_W;
  assign bad_accept = accept && !code_ok;

  // in_ready and busy are registered from the next state, so they line up with y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      y            <= '0;
      y_valid      <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      bus.in_ready <= 1'b0;
    end else begin
`ifdef DECODER_ONEHOT_STICKY_ERR_EN
      if (bad_accept)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
`else
      err <= bad_accept;
`endif
      case (state)
        S_IDLE: begin
          if (accept && code_ok) begin
            state        <= S_DRIVE;
            cnt          <= CNT_W'(HOLD - 1);
            y            <= OUT_W'(1) << code;
            y_valid      <= 1'b1;
            busy         <= 1'b1;
            bus.in_ready <= 1'b0;
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            y       <= '0;
            y_valid <= 1'b0;
            if (GAP == 0) begin
              state        <= S_IDLE;
              busy         <= 1'b0;
              bus.in_ready <= 1'b1;
            end else begin
              state <= S_GAP;
              cnt   <= CNT_W'(GAP - 1);
            end
          end
        end
        S_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            bus.in_ready <= 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          cnt          <= '0;
          y            <= '0;
          y_valid      <= 1'b0;
          busy         <= 1'b0;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_onehot_ctrl.sv
// Bench for decoder_onehot_ctrl: a default instance (OUT_W=4) and an OUT_W=3 instance checked against a timing model.
module tb_decoder_onehot_ctrl;

  localparam int HOLD = 3;
  localparam int GAP  = 1;
  localparam int FAR  = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decoder_onehot_ctrl_if #(.IN_W(2)) bus0 ();
  decoder_onehot_ctrl_if #(.IN_W(2)) bus1 ();

  logic [3:0] y0;
  logic [2:0] y1;
  logic       yv0, yv1, busy0, busy1, err0, err1;
  logic       vld [2];
  logic [1:0] a_in [2];
  logic       clr [2];

  assign bus0.in_valid = vld[0];
  assign bus0.a        = a_in[0];
  assign bus1.in_valid = vld[1];
  assign bus1.a        = a_in[1];

  decoder_onehot_ctrl #(.IN_W(2), .OUT_W(4), .HOLD(HOLD), .GAP(GAP)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .y(y0), .y_valid(yv0), .busy(busy0), .err(err0)
`ifdef DECODER_ONEHOT_STICKY_ERR_EN
    , .err_clr(clr[0])
`endif
  );

  decoder_onehot_ctrl #(.IN_W(2), .OUT_W(3), .HOLD(HOLD), .GAP(GAP)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .y(y1), .y_valid(yv1), .busy(busy1), .err(err1)
`ifdef DECODER_ONEHOT_STICKY_ERR_EN
    , .err_clr(clr[1])
`endif
  );

  // Model: outputs follow from how many edges have passed since the last valid accept.
  int  n_vec = 0;
  int  n_err = 0;
  int  outw [2] = '{4, 3};
  bit  started [2];
  int  since [2];
  int  code [2];
  bit  err_m [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready(int i);
    return started[i] && (since[i] > HOLD + GAP);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      started[i] = 1'b0;
      since[i]   = FAR;
      code[i]    = 0;
      err_m[i]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit acc, bad;
      acc = vld[i] && m_ready(i);
      bad = acc && (int'(a_in[i]) >= outw[i]);
      if (acc && !bad) begin
        since[i] = 1;
        code[i]  = int'(a_in[i]);
      end else if (since[i] < FAR) begin
        since[i]++;
      end
      started[i] = 1'b1;
`ifdef DECODER_ONEHOT_STICKY_ERR_EN
      if (bad)
        err_m[i] = 1'b1;
      else if (clr[i])
        err_m[i] = 1'b0;
`else
      err_m[i] = bad;
`endif
    end
  endtask

  task automatic check_inst(input int i, input logic [3:0] yo, input logic yvo, input logic bo,
                            input logic ro, input logic eo);
    logic [3:0] ey;
    bit drive;
    drive = (since[i] >= 1) && (since[i] <= HOLD);
    ey    = drive ? 4'(1 << code[i]) : 4'd0;
    chk($sformatf("y%0d", i), 32'(yo), 32'(ey));
    chk($sformatf("y_valid%0d", i), 32'(yvo), 32'(drive));
    chk($sformatf("busy%0d", i), 32'(bo), 32'((since[i] >= 1) && (since[i] <= HOLD + GAP)));
    chk($sformatf("in_ready%0d", i), 32'(ro), 32'(m_ready(i)));
    chk($sformatf("err%0d", i), 32'(eo), 32'(err_m[i]));
    chk($sformatf("onehot%0d", i), 32'($countones(yo) <= 1), 32'd1);
  endtask

  task automatic check_all();
    check_inst(0, y0, yv0, busy0, bus0.in_ready, err0);
    check_inst(1, {1'b0, y1}, yv1, busy1, bus1.in_ready, err1);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v0, input logic [1:0] c0, input logic v1, input logic [1:0] c1);
    vld[0] = v0; a_in[0] = c0;
    vld[1] = v1; a_in[1] = c1;
  endtask

  initial begin
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    clr[0] = 1'b0; clr[1] = 1'b0;
    model_reset();
    #12 check_all();
    @(negedge clk) rst_n = 1'b1;
    step();

    // Single accept of code 2 on the default instance.
    drive(1'b1, 2'd2, 1'b0, 2'd0);
    step();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    repeat (6) step();

    // in_valid held high: code 3, then code 0 waits for the next accept window.
    drive(1'b1, 2'd3, 1'b0, 2'd0);
    step();
    drive(1'b1, 2'd0, 1'b0, 2'd0);
    repeat (9) step();

    // Invalid code on the narrow instance, then a valid one.
    drive(1'b0, 2'd0, 1'b1, 2'd3);
    step();
    drive(1'b0, 2'd0, 1'b1, 2'd1);
    step();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    repeat (6) step();

    // Reset asserted in the second DRIVE cycle clears outputs without an edge.
    drive(1'b1, 2'd1, 1'b1, 2'd2);
    step();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    step();
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    repeat (2) step();
    @(negedge clk) rst_n = 1'b1;
    repeat (5) step();

    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 8) < 5, 2'($urandom_range(3, 0)), ($urandom % 8) < 5, 2'($urandom_range(3, 0)));
      clr[0] = ($urandom % 8) == 0;
      clr[1] = ($urandom % 8) == 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_onehot_ctrl.md
Name: decoder_onehot_ctrl

Overview:
Sequential binary-to-one-hot decoder. It is the decode-side counterpart to the team's 4x2 encoders. It accepts an encoded index over a valid/ready handshake and drives the matching one-hot line `y` for a fixed HOLD window, followed by a GAP window. It sits downstream of the encoders and drives select/enable lines that need a guaranteed pulse width and spacing.

Parameters:
- IN_W, 2, width of encoded input `a`.
- OUT_W, 4, width of one-hot output `y`; must be ≤ 2**IN_W. Codes ≥ OUT_W are invalid.
- HOLD, 3, cycles `y` stays asserted per accepted code; must be ≥ 1.
- GAP, 1, forced idle cycles after HOLD before the next accept; must be ≥ 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a code on `a`.
- in_ready  out  1  block can accept; registered.
- a  in  IN_W  encoded index; sampled only on accept.
- y  out  OUT_W  one-hot output; registered.
- y_valid  out  1  high whenever `y` is non-zero (DRIVE state).
- busy  out  1  state != IDLE.
- err  out  1  invalid-code indication (see Optional Feature).

Behaviour:
- Reset:
  - Asserting rst_n low immediately forces: state=IDLE, y=0, y_valid=0, busy=0, err=0, in_ready=0, counter=0.
  - On the first rising clk edge after rst_n release, in_ready goes 1.
- States: IDLE, DRIVE, GAP. Down-counter width is clog2(max(HOLD,GAP)+1).
- Accept: in_valid && in_ready at a rising edge. `a` is ignored at every other time.
- Registered outputs: in_ready=1 only when next state is IDLE; busy=1 when next state is DRIVE or GAP.
- IDLE, accept with a < OUT_W:
  - Next cycle: y = 1 << a, y_valid=1, busy=1, in_ready=0, state=DRIVE, cnt=HOLD-1.
  - Latency from accept edge to y asserted: 1 cycle.
- IDLE, accept with a ≥ OUT_W:
  - The code is consumed and y stays 0.
  - err=1 for exactly one cycle (next cycle).
  - State stays IDLE; in_ready stays 1.
- DRIVE:
  - cnt≠0: cnt decrements; y is held.
  - cnt==0 and GAP==0: next state IDLE; y=0, y_valid=0, busy=0, in_ready=1.
  - cnt==0 and GAP>0: next state GAP; cnt=GAP-1; y=0, y_valid=0; busy stays 1.
  - y is asserted for exactly HOLD cycles.
- GAP:
  - y=0; cnt decrements.
  - cnt==0: next state IDLE with in_ready=1.
  - Outputs are low for exactly GAP cycles.
- Throughput: at most one code per HOLD+GAP+1 cycles. in_valid held high back-to-back yields y pulses spaced HOLD+GAP+1 cycles apart.
- y is always zero or exactly one-hot; never multi-hot.
- Reset mid-DRIVE/GAP: outputs clear asynchronously; the in-flight code is discarded, never replayed.
- in_valid dropping while in_ready=0: no effect. No accept is possible outside IDLE.

Optional Feature:
- Macro: DECODER_ONEHOT_STICKY_ERR_EN.
- Defined:
  - err is sticky: set on an invalid-code accept and held until rst_n low or the new input port `err_clr` (1 bit, in) is high at a rising edge.
  - If err_clr and an invalid accept occur on the same edge, set wins: err=1.
  - The err_clr port exists only when the macro is defined.
- Undefined: err is a single-cycle pulse as in Behaviour, and there is no err_clr port.

Test Plan:
- Reset, then release, with defaults -> all outputs 0 during reset; in_ready=1 one edge after release; y=0.
- Defaults, accept a=2'b10 -> next cycle y=4'b0100, y_valid=1 for 3 cycles; then 1 GAP cycle with y=0, busy=1; in_ready=1 on cycle 5 after accept.
- Defaults, in_valid held high with a=3, then a=0 -> y=4'b1000 for 3 cycles, 1-cycle gap, then y=4'b0001 for 3 cycles; the second accept occurs exactly 5 cycles after the first.
- OUT_W=3, accept a=3 -> y stays 3'b000, err=1 for 1 cycle, in_ready remains 1. Then accept a=1 -> y=3'b010.
- Defaults, accept a=1, assert rst_n low in the 2nd DRIVE cycle -> y=0 and busy=0 immediately (before next edge). After release, no residual pulse; in_ready returns 1 after one edge.
- Macro defined, OUT_W=3: invalid a=3 -> err=1 and stays 1 across 10 cycles and a valid accept; err_clr=1 for one edge -> err=0. err_clr on the same edge as an invalid accept -> err=1.
